bcd_to_binary: RTL and testbench
================================

Name: bcd_to_binary

Overview:
- Registered converter from packed two-digit BCD (tens nibble, units nibble) to unsigned binary.
- Sits on small-display and keypad datapaths, where decimal values in the range 0..15 are converted for downstream binary logic.
- Flags BCD digits that are not legal, and flags results too large for the binary output width.
- One-cycle latency, valid-qualified, no backpressure.

Parameters:
- N_DIGITS, default 2: number of BCD digits on the input. Input width is 4*N_DIGITS. The most significant nibble is the most significant digit.
- BIN_W, default 4: width of the binary output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies bcd on this clock edge.
- bcd  input  4*N_DIGITS  packed BCD value. Default layout: [7:4] tens, [3:0] units.
- out_valid  output  1  binary, bcd_err and ovf are valid this cycle.
- binary  output  BIN_W  converted unsigned value.
- bcd_err  output  1  at least one input nibble was greater than 9.
- ovf  output  1  decimal value exceeded 2^BIN_W - 1.

Behaviour:
- Reset: while rst_n = 0, all outputs are 0, asynchronously. Release of reset is synchronous to clk. Reset asserted mid-operation discards the pending result.
- Conversion is combinational: value = sum over digits i of digit_i * 10^i. Compute with an internal width of ceil(log2(10^N_DIGITS)) bits; 7 bits for the default.
- Implement the conversion as shift-and-add, times 10 = (x<<3)+(x<<1), folded per digit, or as reverse double-dabble. Do not use a generic multiplier.
- Capture on the rising clk edge when in_valid = 1:
  - out_valid <= 1.
  - bcd_err <= OR over all nibbles of (nibble > 9).
  - ovf <= (value > 2^BIN_W - 1) and not bcd_err.
  - binary <= value if no error. On ovf, binary <= all ones (saturate). On bcd_err, binary <= 0.
- When in_valid = 0 on a clock edge: out_valid <= 0. binary, bcd_err and ovf hold their last values.
- Latency is exactly 1 cycle. Back-to-back in_valid gives one result every cycle.
- No backpressure; a consumer must take the result in the cycle out_valid is high.
- bcd_err takes priority over ovf. ovf is 0 whenever bcd_err is 1.
- Boundaries, default parameters:
  - 0x00 -> 0.
  - 0x09 -> 9.
  - 0x10 -> 10.
  - 0x15 -> 15, the maximum value without overflow.
  - 0x16 -> ovf = 1, binary = 4'hF.
  - 0x99 -> ovf = 1, binary = 4'hF.
  - 0x0A, 0xA0 or 0xFF -> bcd_err = 1, binary = 0.
- X or Z on bcd while in_valid = 0 must not affect the outputs.

Test Plan:
- Reset: assert rst_n = 0 mid-stream, with no clock edge -> outputs go to 0 immediately. Release, drive in_valid = 0 -> out_valid stays 0.
- Full legal sweep: bcd = 0x00..0x09, then 0x10..0x15, each with in_valid = 1 on consecutive cycles -> one cycle later binary = 0..15 in order, out_valid = 1 every cycle, bcd_err = ovf = 0.
- Overflow: bcd = 0x16 -> binary = 4'hF, ovf = 1. bcd = 0x99 -> binary = 4'hF, ovf = 1. bcd_err = 0 for both.
- Illegal digits: bcd = 0x0A -> bcd_err = 1, binary = 0. bcd = 0xA5 -> bcd_err = 1, ovf = 0. bcd = 0xFF -> bcd_err = 1.
- Hold behaviour: bcd = 0x12 with in_valid = 1, then in_valid = 0 for 3 cycles with bcd = 0x07 -> binary stays 12 and out_valid = 0 during the idle cycles.
- Parameter variant: N_DIGITS = 3, BIN_W = 10. bcd = 0x999 -> binary = 999, ovf = 0. bcd = 0x123 -> binary = 123.

Source files
------------

// File: rtl/bcd_to_binary.sv
// bcd_to_binary
// Registered converter from packed multi-digit BCD to unsigned binary.
// Digits are folded most-significant first with a shift-and-add times-ten
// step, then checked for illegal nibbles and for overflow of the output width.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   qualifies bcd on this clock edge
//   bcd        packed BCD, most significant digit in the top nibble
//   out_valid  binary/bcd_err/ovf valid this cycle (one-cycle pulse per input)
//   binary     converted value; saturates to all ones on ovf, 0 on bcd_err
//   bcd_err    at least one input nibble was greater than 9
//   ovf        legal decimal value did not fit in BIN_W bits
module bcd_to_binary #(
  parameter int N_DIGITS = 2,
  parameter int BIN_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [4*N_DIGITS-1:0] bcd,
  output logic                  out_valid,
  output logic [BIN_W-1:0]      binary,
  output logic                  bcd_err,
  output logic                  ovf
);

  localparam int VAL_W = $clog2(10 ** N_DIGITS);
  // Comparison width covers both the value and the output range, so the
  // overflow test also works when BIN_W is wider than the value.
  localparam int CMP_W = (VAL_W > BIN_W) ? VAL_W : BIN_W;
  localparam int EXT_W = CMP_W + 1;
  localparam logic [EXT_W-1:0] MAX_BIN = {{(EXT_W-BIN_W){1'b0}}, {BIN_W{1'b1}}};

  logic [VAL_W-1:0] value;
  logic [EXT_W-1:0] value_ext;
  logic             err_c;
  logic             ovf_c;
  logic [BIN_W-1:0] bin_c;

  // value = value*10 + digit, with *10 as (x<<3)+(x<<1). An illegal digit may
  // wrap the accumulator, which is harmless because bcd_err forces binary to 0.
  always_comb begin
    value = '0;
    err_c = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      value = (value << 3) + (value << 1) + VAL_W'(bcd[4*i +: 4]);
      if (bcd[4*i +: 4] > 4'd9) begin
        err_c = 1'b1;
      end
    end
  end

  assign value_ext = EXT_W'(value);
  assign ovf_c     = !err_c && (value_ext > MAX_BIN);

  always_comb begin
    if (err_c) begin
      bin_c = '0;
    end else if (ovf_c) begin
      bin_c = '1;
    end else begin
      bin_c = value_ext[BIN_W-1:0];
    end
  end

  // Result fields only load on in_valid, so bcd may be X/Z while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      binary    <= '0;
      bcd_err   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        binary  <= bin_c;
        bcd_err <= err_c;
        ovf     <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_valid3;
  logic [7:0]  bcd;
  logic [11:0] bcd3;
  logic        out_valid, out_valid3;
  logic [3:0]  binary;
  logic [9:0]  binary3;
  logic        bcd_err, bcd_err3, ovf, ovf3;

  bcd_to_binary dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .bcd(bcd),
    .out_valid(out_valid), .binary(binary), .bcd_err(bcd_err), .ovf(ovf)
  );

  bcd_to_binary #(.N_DIGITS(3), .BIN_W(10)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .bcd(bcd3),
    .out_valid(out_valid3), .binary(binary3), .bcd_err(bcd_err3), .ovf(ovf3)
  );

  typedef struct {
    logic [9:0] bin;
    logic       err;
    logic       ovf;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitors: pop one expectation each cycle the DUT presents a result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (out_valid === 1'b1) begin
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=1 required=0 at %0t", $time);
      end else begin
        e = q2.pop_front();
        chk("binary", 32'(binary), 32'(e.bin));
        chk("bcd_err", 32'(bcd_err), 32'(e.err));
        chk("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  always @(posedge clk) begin
    exp_t e3;
    #1;
    if (out_valid3 === 1'b1) begin
      if (q3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid3 actual=1 required=0 at %0t", $time);
      end else begin
        e3 = q3.pop_front();
        chk("binary3", 32'(binary3), 32'(e3.bin));
        chk("bcd_err3", 32'(bcd_err3), 32'(e3.err));
        chk("ovf3", 32'(ovf3), 32'(e3.ovf));
      end
    end
  end

  task automatic send2(input logic [7:0] v, input logic [3:0] b, input logic e, input logic o);
    @(negedge clk);
    in_valid = 1'b1;
    bcd      = v;
    q2.push_back('{bin: 10'(b), err: e, ovf: o});
  endtask

  task automatic send3(input logic [11:0] v, input logic [9:0] b, input logic e, input logic o);
    @(negedge clk);
    in_valid3 = 1'b1;
    bcd3      = v;
    q3.push_back('{bin: b, err: e, ovf: o});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_binary"}, 32'(binary), 32'd0);
    chk({tag, "_bcd_err"}, 32'(bcd_err), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_out_valid3"}, 32'(out_valid3), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_valid3 = 1'b0;
    bcd       = '0;
    bcd3      = '0;

    // Power-on reset applied between clock edges.
    #2 rst_n = 1'b0;
    #1 check_zero("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2 chk("idle_after_release", 32'(out_valid), 32'd0);

    // Full legal sweep 0..15, back to back.
    for (int i = 0; i < 16; i++) begin
      send2((i < 10) ? 8'(i) : 8'(16 + i - 10), 4'(i), 1'b0, 1'b0);
    end
    // Overflow and illegal digits.
    send2(8'h16, 4'hF, 1'b0, 1'b1);
    send2(8'h99, 4'hF, 1'b0, 1'b1);
    send2(8'h0A, 4'h0, 1'b1, 1'b0);
    send2(8'hA5, 4'h0, 1'b1, 1'b0);
    send2(8'hFF, 4'h0, 1'b1, 1'b0);
    send2(8'hA0, 4'h0, 1'b1, 1'b0);

    // Hold: result stays while idle, including with X on bcd.
    send2(8'h12, 4'd12, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    bcd      = 8'h07;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #2;
      chk("hold_out_valid", 32'(out_valid), 32'd0);
      chk("hold_binary", 32'(binary), 32'd12);
    end
    @(negedge clk);
    bcd = 'x;
    @(posedge clk);
    #2;
    chk("hold_x_binary", 32'(binary), 32'd12);
    chk("hold_x_bcd_err", 32'(bcd_err), 32'd0);
    chk("hold_x_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    bcd = 8'h00;

    // Three-digit, 10-bit variant.
    send3(12'h999, 10'd999, 1'b0, 1'b0);
    send3(12'h123, 10'd123, 1'b0, 1'b0);
    send3(12'h000, 10'd0, 1'b0, 1'b0);
    send3(12'h9A9, 10'd0, 1'b1, 1'b0);
    @(negedge clk);
    in_valid3 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-stream: the pending 0x09 capture is discarded.
    send2(8'h15, 4'd15, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    bcd      = 8'h09;
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    in_valid = 1'b0;
    @(negedge clk);
    check_zero("midrst_held");
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #2 chk("after_midrst_out_valid", 32'(out_valid), 32'd0);
    end

    repeat (3) @(negedge clk);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
